// File: rtl/unroller.sv
// Unroller: gathers NUM/ROLL_NUM consecutive ROLL_NUM-element beats into one registered NUM-element frame.
// A full frame can be drained and the first beat of the next frame accepted in the same cycle.
module unroller #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM        = 8,
   parameter int ROLL_NUM   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM-1:0],
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [NUM-1:0],
   output logic                  data_out_valid,
   input  logic                  data_out_ready
);

   localparam bit PARAMS_OK = (ROLL_NUM > 0) && (NUM > 0) && ((NUM % ((ROLL_NUM > 0) ? ROLL_NUM : 1)) == 0);
   localparam int CYCLES    = PARAMS_OK ? NUM / ROLL_NUM : 1;
   localparam int CNT_W     = $clog2(CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES);

   if (!PARAMS_OK) begin : g_bad_params
      $error("unroller: NUM (%0d) must be a non-zero multiple of ROLL_NUM (%0d)", NUM, ROLL_NUM);
   end

   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      wr_beat;
   logic [DATA_WIDTH-1:0] frame [NUM-1:0];
   logic                  in_hs;
   logic                  out_hs;

   assign data_out_valid = (cnt == CNT_FULL);
   assign data_in_ready  = (cnt != CNT_FULL) || data_out_ready;
   assign in_hs          = data_in_valid && data_in_ready;
   assign out_hs         = data_out_valid && data_out_ready;
   assign data_out       = frame;

   // A beat arriving while the full frame drains starts the next frame at beat 0.
   assign wr_beat = out_hs ? '0 : cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < NUM; i++) begin
            frame[i] <= '0;
         end
      end else begin
         if (out_hs && in_hs) begin
            cnt <= CNT_W'(1);
         end else if (out_hs) begin
            cnt <= '0;
         end else if (in_hs) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (in_hs) begin
            for (int i = 0; i < NUM; i++) begin
               if (int'(wr_beat) == (i / ROLL_NUM)) begin
                  frame[i] <= data_in[i % ROLL_NUM];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_unroller.sv
// Bench for unroller: directed cases on the default geometry plus random valid/ready on 12/3 and 4/4,
// all frames checked against a queue of accepted input elements.
module tb_unroller;

   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int num_of(input int g);
      case (g)
         0:       return 8;
         1:       return 12;
         default: return 4;
      endcase
   endfunction

   function automatic int roll_of(input int g);
      case (g)
         0:       return 2;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int N = num_of(g);
      localparam int R = roll_of(g);
      localparam int C = N / R;

      logic         rst;
      logic [W-1:0] din [R-1:0];
      logic         din_valid;
      logic         din_ready;
      logic [W-1:0] dout [N-1:0];
      logic         dout_valid;
      logic         dout_ready;
      logic [W-1:0] exp_q [$];
      int           frames = 0;
      bit           fin = 1'b0;
      int           bad;
      logic [W-1:0] e;
      logic [W-1:0] bad_act;
      logic [W-1:0] bad_exp;

      unroller #(.DATA_WIDTH(W), .NUM(N), .ROLL_NUM(R)) dut (
         .clk           (clk),
         .rst           (rst),
         .data_in       (din),
         .data_in_valid (din_valid),
         .data_in_ready (din_ready),
         .data_out      (dout),
         .data_out_valid(dout_valid),
         .data_out_ready(dout_ready)
      );

      // Scoreboard: frames pop first, since they were built from beats accepted earlier.
      always @(negedge clk) begin
         if (rst) begin
            exp_q.delete();
         end else begin
            if (dout_valid && dout_ready) begin
               frames++;
               checks++;
               if (exp_q.size() < N) begin
                  errors++;
                  $display("FAIL frame_short inst=%0d frame=%0d: queued %0d elements, expected %0d", g, frames, exp_q.size(), N);
                  exp_q.delete();
               end else begin
                  bad = -1;
                  for (int i = 0; i < N; i++) begin
                     e = exp_q.pop_front();
                     if (dout[i] !== e && bad < 0) begin
                        bad     = i;
                        bad_act = dout[i];
                        bad_exp = e;
                     end
                  end
                  if (bad >= 0) begin
                     errors++;
                     $display("FAIL frame_data inst=%0d frame=%0d slot=%0d: got %0h, expected %0h", g, frames, bad, bad_act, bad_exp);
                  end
               end
            end
            if (din_valid && din_ready) begin
               for (int j = 0; j < R; j++) begin
                  exp_q.push_back(din[j]);
               end
            end
         end
      end

      task automatic send();
         int n;
         n = 0;
         din_valid = 1'b1;
         @(negedge clk);
         while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%0d: ready 0 after %0d cycles, expected 1", g, n);
         end
         @(posedge clk);
         #1;
      endtask

      task automatic beat2(input int hi, input int lo);
         din[1] = W'(hi);
         din[0] = W'(lo);
         send();
      endtask

      if (g == 0) begin : g_directed
         initial begin : directed
            logic [W-1:0] acc;
            int           cyc_q [$];
            int           ready_low;

            rst        = 1'b1;
            din_valid  = 1'b1;
            din[0]     = 16'hdead;
            din[1]     = 16'hbeef;
            dout_ready = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("rst_in_ready", din_ready, 1);
            chk("rst_out_valid", dout_valid, 0);
            @(posedge clk);
            #1;
            rst       = 1'b0;
            din_valid = 1'b0;
            @(negedge clk);
            acc = '0;
            for (int i = 0; i < N; i++) acc |= dout[i];
            chk("rst_dout_zero", acc, 0);
            chk("rst_out_valid_after", dout_valid, 0);
            chk("rst_in_ready_after", din_ready, 1);
            @(posedge clk);
            #1;

            // basic frame, one cycle of valid
            for (int b = 0; b < 4; b++) begin
               beat2(2 * b + 1, 2 * b);
               if (b < 3) chk("basic_valid_early", dout_valid, 0);
            end
            din_valid = 1'b0;
            @(negedge clk);
            chk("basic_valid", dout_valid, 1);
            for (int i = 0; i < N; i++) chk("basic_slot", dout[i], i);
            @(negedge clk);
            chk("basic_valid_one_cycle", dout_valid, 0);
            @(posedge clk);
            #1;

            // backpressure, then drain and fill in one cycle
            dout_ready = 1'b0;
            for (int b = 0; b < 4; b++) beat2(2 * b + 11, 2 * b + 10);
            din[1] = 16'd9;
            din[0] = 16'd8;
            for (int t = 0; t < 5; t++) begin
               @(negedge clk);
               chk("bp_valid", dout_valid, 1);
               chk("bp_in_ready", din_ready, 0);
               acc = '0;
               for (int i = 0; i < N; i++) acc |= dout[i] ^ W'(10 + i);
               chk("bp_hold", acc, 0);
            end
            @(posedge clk);
            #1;
            dout_ready = 1'b1;
            @(negedge clk);
            chk("fill_in_ready", din_ready, 1);
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            @(negedge clk);
            chk("fill_not_full", dout_valid, 0);
            @(posedge clk);
            #1;
            for (int b = 0; b < 3; b++) beat2(2 * b + 21, 2 * b + 20);
            din_valid = 1'b0;
            chk("fill_full_after_3", dout_valid, 1);
            for (int i = 0; i < N; i++) chk("fill_slot", dout[i], (i < 2) ? 8 + i : 18 + i);
            @(negedge clk);
            @(negedge clk);
            chk("fill_drained", dout_valid, 0);
            @(posedge clk);
            #1;

            // back-to-back stream of 12 beats
            ready_low = 0;
            fork
               begin
                  for (int b = 0; b < 12; b++) beat2(2 * b + 101, 2 * b + 100);
                  din_valid = 1'b0;
               end
               begin
                  for (int t = 0; t < 16; t++) begin
                     @(negedge clk);
                     if (dout_valid) cyc_q.push_back(t);
                     if (!din_ready) ready_low++;
                  end
               end
            join
            chk("b2b_frames", cyc_q.size(), 3);
            chk("b2b_ready_low", ready_low, 0);
            if (cyc_q.size() == 3) begin
               chk("b2b_first", cyc_q[0], 4);
               chk("b2b_gap1", cyc_q[1] - cyc_q[0], 4);
               chk("b2b_gap2", cyc_q[2] - cyc_q[1], 4);
            end
            @(posedge clk);
            #1;

            // reset in the middle of a frame
            beat2(201, 200);
            beat2(203, 202);
            din_valid = 1'b0;
            rst       = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            acc = '0;
            for (int i = 0; i < N; i++) acc |= dout[i];
            chk("rstmid_zero", acc, 0);
            chk("rstmid_valid", dout_valid, 0);
            @(posedge clk);
            #1;
            for (int b = 0; b < 4; b++) beat2(2 * b + 301, 2 * b + 300);
            din_valid = 1'b0;
            @(negedge clk);
            chk("rstmid_full", dout_valid, 1);
            for (int i = 0; i < N; i++) chk("rstmid_slot", dout[i], 300 + i);
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("dir_frames", frames, 7);
            chk("dir_leftover", exp_q.size(), 0);
            fin = 1'b1;
         end
      end else begin : g_random
         initial begin : random_run
            bit stop;
            stop       = 1'b0;
            rst        = 1'b1;
            din_valid  = 1'b0;
            dout_ready = 1'b0;
            for (int j = 0; j < R; j++) din[j] = '0;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            fork
               while (!stop) begin
                  @(posedge clk);
                  #1;
                  dout_ready = stop ? 1'b1 : ($urandom_range(0, 1) == 1);
               end
            join_none
            for (int b = 0; b < 1000; b++) begin
               repeat ($urandom_range(0, 2)) begin
                  din_valid = 1'b0;
                  for (int j = 0; j < R; j++) din[j] = W'($urandom);
                  @(posedge clk);
                  #1;
               end
               for (int j = 0; j < R; j++) din[j] = W'($urandom);
               send();
            end
            din_valid = 1'b0;
            stop      = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            dout_ready = 1'b1;
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("rand_frames", frames, 1000 / C);
            chk("rand_leftover", exp_q.size(), 0);
            fin = 1'b1;
         end
      end
   end

   initial begin : summary
      int n;
      n = 0;
      while (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      if (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin)) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: stimulus unfinished after %0d cycles, expected completion", n);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
